serial_logic16: RTL and testbench

- Bit-serial counterpart of the 16-bit parallel bitwise gate set.
- Accepts two 16-bit operands and an opcode on a start handshake, then evaluates one bit per clock, MSB-first (index 0 first, 15 last).
- Streams each result bit out as it is produced and assembles the full 16-bit word, signalling completion.
- Sits beside the parallel logic unit wherever area matters more than latency, and serves as a serial result source for downstream shifters.

---
 rtl/serial_logic16_pkg.sv | 18 +
 rtl/serial_logic16_bit_op1.sv | 33 +++
 rtl/serial_logic16.sv | 134 +++++++++++++
 tb/tb_serial_logic16.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_logic16_pkg.sv
// rtl/serial_logic16_pkg.sv - shared opcodes, state encoding and width defaults for serial_logic16
package serial_logic16_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int CNT_W_DEF = 4;

    localparam logic [1:0] OP_NOT = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_XOR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_logic16_bit_op1.sv
// rtl/serial_logic16_bit_op1.sv - single-bit NOT/AND/OR/XOR with 4:1 select
module bit_op1
    import serial_logic16_pkg::*;
(
    input  logic [1:0] op,
    input  logic       x,
    input  logic       y,
    output logic       z
);

    logic z_not;
    logic z_and;
    logic z_or;
    logic z_xor;

    assign z_not = ~x;
    assign z_and = x & y;
    assign z_or  = x | y;
    // XOR composed from the NOT/AND/OR primitives only
    assign z_xor = (x & ~y) | (~x & y);

    always_comb begin
        z = z_not;
        case (op)
            OP_NOT:  z = z_not;
            OP_AND:  z = z_and;
            OP_OR:   z = z_or;
            OP_XOR:  z = z_xor;
            default: z = z_not;
        endcase
    end

endmodule

// File: rtl/serial_logic16.sv
// rtl/serial_logic16.sv - bit-serial 16-bit bitwise logic unit, index 0 (MSB) first
module serial_logic16
    import serial_logic16_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [0:WIDTH-1]   a,
    input  logic [0:WIDTH-1]   b,
    input  logic               cancel,
    output logic               busy,
    output logic               bit_out,
    output logic               bit_valid,
    output logic [CNT_W-1:0]   bit_idx,
    output logic [0:WIDTH-1]   out,
    output logic               out_valid,
    output logic               done
);

    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(WIDTH - 1);

    state_t             state, state_d;
    logic [CNT_W-1:0]   idx, idx_d;
    logic [0:WIDTH-1]   a_l, a_l_d;
    logic [0:WIDTH-1]   b_l, b_l_d;
    logic [1:0]         op_l, op_l_d;
    logic               busy_d;
    logic               bit_out_d;
    logic               bit_valid_d;
    logic [CNT_W-1:0]   bit_idx_d;
    logic [0:WIDTH-1]   out_d;
    logic               out_valid_d;
    logic               done_d;
    logic               z;

    bit_op1 u_bit_op1 (
        .op (op_l),
        .x  (a_l[idx]),
        .y  (b_l[idx]),
        .z  (z)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            idx       <= '0;
            a_l       <= '0;
            b_l       <= '0;
            op_l      <= '0;
            busy      <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
            bit_idx   <= '0;
            out       <= '0;
            out_valid <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            idx       <= idx_d;
            a_l       <= a_l_d;
            b_l       <= b_l_d;
            op_l      <= op_l_d;
            busy      <= busy_d;
            bit_out   <= bit_out_d;
            bit_valid <= bit_valid_d;
            bit_idx   <= bit_idx_d;
            out       <= out_d;
            out_valid <= out_valid_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        a_l_d       = a_l;
        b_l_d       = b_l;
        op_l_d      = op_l;
        busy_d      = busy;
        bit_out_d   = bit_out;
        bit_valid_d = 1'b0;
        bit_idx_d   = bit_idx;
        out_d       = out;
        out_valid_d = out_valid;
        done_d      = 1'b0;

        case (state)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (start) begin
                    a_l_d       = a;
                    b_l_d       = b;
                    op_l_d      = op;
                    idx_d       = '0;
                    state_d     = ST_RUN;
                    busy_d      = 1'b1;
                    out_valid_d = 1'b0;
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    // abort without writing this step's bit; partial word stays in out
                    state_d     = ST_IDLE;
                    idx_d       = '0;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b0;
                end else begin
                    out_d[idx]  = z;
                    bit_out_d   = z;
                    bit_idx_d   = idx;
                    bit_valid_d = 1'b1;
                    if (idx == IDX_LAST) begin
                        state_d     = ST_DONE;
                        idx_d       = '0;
                        busy_d      = 1'b0;
                        out_valid_d = 1'b1;
                        done_d      = 1'b1;
                    end else begin
                        idx_d = idx + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_serial_logic16.sv
// tb/tb_serial_logic16.sv - scoreboard bench for serial_logic16
module tb_serial_logic16;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [0:15] a = '0;
    logic [0:15] b = '0;
    logic        cancel = 1'b0;
    logic        busy;
    logic        bit_out;
    logic        bit_valid;
    logic [3:0]  bit_idx;
    logic [0:15] out;
    logic        out_valid;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic        exp_bit_q[$];
    logic [0:15] exp_word_q[$];

    logic        obs_bit[16];
    logic [3:0]  obs_idx[16];
    int          nbits;
    int          ndone;
    int          done_cyc;
    logic [0:15] ow;
    logic        ov;
    logic        last_bv;

    serial_logic16 dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .cancel    (cancel),
        .busy      (busy),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_idx   (bit_idx),
        .out       (out),
        .out_valid (out_valid),
        .done      (done)
    );

    always #5 clock = ~clock;

    function automatic logic [0:15] model(input logic [1:0] o, input logic [0:15] x, input logic [0:15] y);
        case (o)
            2'b00:   return ~x;
            2'b01:   return x & y;
            2'b10:   return x | y;
            default: return x ^ y;
        endcase
    endfunction

    task automatic issue(input logic [1:0] o, input logic [0:15] x, input logic [0:15] y);
        logic [0:15] w;
        w = model(o, x, y);
        exp_word_q.push_back(w);
        for (int i = 0; i < 16; i++) exp_bit_q.push_back(w[i]);
        op = o;
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    // observation only: edge k of the run is loop iteration c=k
    task automatic capture(input int cancel_at, input int start_at, input int max_cyc);
        nbits = 0;
        ndone = 0;
        done_cyc = -1;
        ow = '0;
        ov = 1'b0;
        last_bv = 1'b0;
        for (int c = 1; c <= max_cyc; c++) begin
            if (c == cancel_at) cancel = 1'b1;
            if (c == start_at) begin
                start = 1'b1;
                op = 2'b11;
                a = 16'hFFFF;
                b = 16'hFFFF;
            end
            @(posedge clock);
            #1;
            cancel = 1'b0;
            start = 1'b0;
            if (bit_valid) begin
                if (nbits < 16) begin
                    obs_bit[nbits] = bit_out;
                    obs_idx[nbits] = bit_idx;
                end
                nbits++;
            end
            if (done) begin
                ndone++;
                done_cyc = c;
                ow = out;
                ov = out_valid;
                last_bv = bit_valid;
                break;
            end
            if (c == cancel_at) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clock);
        #1;
        checks++;
        if ({busy, bit_out, bit_valid, bit_idx, out, out_valid, done} !== 25'd0) begin
            errors++;
            $display("FAIL reset_init got %h want 0", {busy, bit_out, bit_valid, bit_idx, out, out_valid, done});
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        issue(2'b01, 16'hF0F0, 16'hFF00);
        repeat (6) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, bit_out, bit_valid, bit_idx, out, out_valid, done} !== 25'd0) begin
            errors++;
            $display("FAIL reset_async got %h want 0", {busy, bit_out, bit_valid, bit_idx, out, out_valid, done});
        end
        exp_bit_q.delete();
        exp_word_q.delete();
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        capture(0, 0, 24);
        checks++;
        if (ndone !== 0 || out !== 16'h0000 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_after got done=%0d out=%h ov=%b want 0 0000 0", ndone, out, out_valid);
        end
    endtask

    task automatic test_and();
        logic [0:15] w;
        issue(2'b01, 16'hF0F0, 16'hFF00);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL and_busy got %b want 1", busy);
        end
        capture(0, 0, 40);
        checks++;
        if (ndone !== 1 || done_cyc !== 16 || nbits !== 16 || last_bv !== 1'b1) begin
            errors++;
            $display("FAIL and_latency got done=%0d cyc=%0d bits=%0d lastbv=%b want 1 16 16 1", ndone, done_cyc, nbits, last_bv);
        end
        for (int i = 0; i < 16; i++) begin
            logic e;
            e = (exp_bit_q.size() > 0) ? exp_bit_q.pop_front() : 1'bx;
            checks++;
            if (obs_bit[i] !== e || obs_idx[i] !== 4'(i)) begin
                errors++;
                $display("FAIL and_stream[%0d] got %b@%0d want %b@%0d", i, obs_bit[i], obs_idx[i], e, i);
            end
        end
        w = (exp_word_q.size() > 0) ? exp_word_q.pop_front() : 'x;
        checks++;
        if (ow !== w || ov !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL and_word got %h ov=%b busy=%b want %h 1 0", ow, ov, busy, w);
        end
        @(posedge clock);
        #1;
        checks++;
        if (done !== 1'b0 || bit_valid !== 1'b0 || out_valid !== 1'b1 || out !== w) begin
            errors++;
            $display("FAIL and_idle got done=%b bv=%b ov=%b out=%h want 0 0 1 %h", done, bit_valid, out_valid, out, w);
        end
    endtask

    task automatic test_not();
        logic [0:15] w;
        for (int pass = 0; pass < 2; pass++) begin
            issue(2'b00, 16'h8001, (pass == 0) ? 16'hFFFF : 16'h0000);
            capture(0, 0, 40);
            for (int i = 0; i < 16; i++) begin
                logic e;
                e = (exp_bit_q.size() > 0) ? exp_bit_q.pop_front() : 1'bx;
                checks++;
                if (obs_bit[i] !== e || obs_idx[i] !== 4'(i)) begin
                    errors++;
                    $display("FAIL not_stream[%0d] got %b want %b", i, obs_bit[i], e);
                end
            end
            w = (exp_word_q.size() > 0) ? exp_word_q.pop_front() : 'x;
            checks++;
            if (ndone !== 1 || ow !== w || ov !== 1'b1) begin
                errors++;
                $display("FAIL not_word pass%0d got %h done=%0d want %h 1", pass, ow, ndone, w);
            end
        end
        @(posedge clock);
        #1;
        cancel = 1'b1;
        @(posedge clock);
        #1;
        cancel = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || out !== w || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_cancel got ov=%b out=%h busy=%b want 1 %h 0", out_valid, out, busy, w);
        end
    endtask

    task automatic test_back_to_back();
        logic [0:15] w;
        issue(2'b10, 16'h00FF, 16'h0F00);
        capture(0, 5, 40);
        w = (exp_word_q.size() > 0) ? exp_word_q.pop_front() : 'x;
        repeat (16) void'(exp_bit_q.pop_front());
        checks++;
        if (ndone !== 1 || done_cyc !== 16 || ow !== w) begin
            errors++;
            $display("FAIL or_ignore_start got %h done=%0d cyc=%0d want %h 1 16", ow, ndone, done_cyc, w);
        end
        issue(2'b11, 16'hAAAA, 16'hFFFF);
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_launch got done=%b busy=%b ov=%b want 0 1 0", done, busy, out_valid);
        end
        capture(0, 0, 40);
        for (int i = 0; i < 16; i++) begin
            logic e;
            e = (exp_bit_q.size() > 0) ? exp_bit_q.pop_front() : 1'bx;
            checks++;
            if (obs_bit[i] !== e) begin
                errors++;
                $display("FAIL xor_stream[%0d] got %b want %b", i, obs_bit[i], e);
            end
        end
        w = (exp_word_q.size() > 0) ? exp_word_q.pop_front() : 'x;
        checks++;
        if (ndone !== 1 || done_cyc !== 16 || ow !== w) begin
            errors++;
            $display("FAIL xor_word got %h done=%0d cyc=%0d want %h 1 16", ow, ndone, done_cyc, w);
        end
    endtask

    task automatic test_cancel();
        logic [0:15] w;
        issue(2'b11, 16'h1234, 16'hFF0F);
        capture(9, 0, 40);
        checks++;
        if (nbits !== 8 || ndone !== 0 || busy !== 1'b0 || bit_valid !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL cancel_state got bits=%0d done=%0d busy=%b bv=%b ov=%b want 8 0 0 0 0", nbits, ndone, busy, bit_valid, out_valid);
        end
        for (int i = 0; i < 16; i++) begin
            logic e;
            e = (exp_bit_q.size() > 0) ? exp_bit_q.pop_front() : 1'bx;
            if (i < 8) begin
                checks++;
                if (obs_bit[i] !== e) begin
                    errors++;
                    $display("FAIL cancel_stream[%0d] got %b want %b", i, obs_bit[i], e);
                end
            end
        end
        void'(exp_word_q.pop_front());
        capture(0, 0, 20);
        checks++;
        if (ndone !== 0 || nbits !== 0) begin
            errors++;
            $display("FAIL cancel_quiet got done=%0d bits=%0d want 0 0", ndone, nbits);
        end
        issue(2'b01, 16'hFFFF, 16'h1234);
        capture(0, 0, 40);
        w = (exp_word_q.size() > 0) ? exp_word_q.pop_front() : 'x;
        repeat (16) void'(exp_bit_q.pop_front());
        checks++;
        if (ndone !== 1 || ow !== w || ov !== 1'b1) begin
            errors++;
            $display("FAIL after_cancel got %h done=%0d want %h 1", ow, ndone, w);
        end
    endtask

    initial begin
        test_reset();
        test_and();
        test_not();
        test_back_to_back();
        test_cancel();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
